// File: rtl/coeff_compress_pack_if.sv
// Coefficient stream in, packed PK-memory write bus out, for coeff_compress_pack.
// The chk signal exists only when CPACK_CHECKSUM_EN is defined.
interface coeff_compress_pack_if;
    logic        start;
    logic [10:0] base_addr;
    // A coefficient transfers on a clock edge where in_valid && in_ready; in_valid may
    // drop at any time, and out_valid is a write strobe with no backpressure.
    logic        in_valid;
    logic [12:0] in_coeff;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_word;
    logic [10:0] out_addr;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;
`ifdef CPACK_CHECKSUM_EN
    logic [15:0] chk;
`endif

    modport master (
        output start, base_addr, in_valid, in_coeff,
        input  in_ready, out_valid, out_word, out_addr, busy, done, dbg_state
`ifdef CPACK_CHECKSUM_EN
        , input chk
`endif
    );

    modport slave (
        input  start, base_addr, in_valid, in_coeff,
        output in_ready, out_valid, out_word, out_addr, busy, done, dbg_state
`ifdef CPACK_CHECKSUM_EN
        , output chk
`endif
    );
endinterface

// File: rtl/coeff_compress_pack.sv
// Compresses 13-bit coefficients mod Q to D bits and packs them LSB-first into 16-bit
// addressed write words. Optional running XOR checksum under CPACK_CHECKSUM_EN.
module coeff_compress_pack #(
    parameter int Q     = 7681,
    parameter int D     = 10,
    parameter int NCOEF = 64
) (
    input logic clk,
    input logic rst,
    coeff_compress_pack_if.slave bus
);
    localparam int CW = $clog2(NCOEF + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2, S_DONE = 2'd3} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   acc_q;
    logic [D-1:0]    c_q;
    logic            c_vld_q;
    logic [31:0]     buf_q, buf_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [10:0]     widx_q;
    logic [10:0]     base_q;
    logic            out_valid_q;
    logic [15:0]     out_word_q;
    logic [10:0]     out_addr_q;
`ifdef CPACK_CHECKSUM_EN
    logic [15:0]     chk_q;
`endif

    logic            accept;
    logic            start_job;
    logic [31:0]     num;
    logic [D-1:0]    c_new;
    logic [31:0]     ext;
    logic [5:0]      cnt_sum;
    logic            emit;
    logic [15:0]     word_d;

    assign accept    = bus.in_valid && (state_q == S_RUN);
    assign start_job = bus.start && (state_q == S_IDLE);

    // round(x*2^D/Q) done exactly as floor((2x*2^D + Q) / 2Q); Q odd means no ties.
    assign num   = ({19'd0, bus.in_coeff} << (D + 1)) + 32'(Q);
    assign c_new = D'(num / 32'(2 * Q));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (accept && acc_q == CW'(NCOEF - 1)) state_d = S_FLUSH;
            // Emitting the flush word clears cnt, so DONE lands one cycle after it.
            S_FLUSH: if (!c_vld_q && cnt_q == 6'd0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ext     = buf_q | ({{(32 - D){1'b0}}, c_q} << cnt_q);
        cnt_sum = cnt_q + 6'(D);
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
        word_d  = buf_q[15:0];
        if (c_vld_q) begin
            if (cnt_sum >= 6'd16) begin
                emit   = 1'b1;
                word_d = ext[15:0];
                buf_d  = ext >> 16;
                cnt_d  = cnt_sum - 6'd16;
            end else begin
                buf_d = ext;
                cnt_d = cnt_sum;
            end
        end else if (state_q == S_FLUSH && cnt_q != 6'd0) begin
            emit   = 1'b1;
            word_d = buf_q[15:0];
            buf_d  = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            c_q         <= '0;
            c_vld_q     <= 1'b0;
            buf_q       <= '0;
            cnt_q       <= '0;
            widx_q      <= '0;
            base_q      <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_addr_q  <= '0;
`ifdef CPACK_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            c_vld_q     <= accept;
            out_valid_q <= emit;
            if (accept) begin
                c_q   <= c_new;
                acc_q <= acc_q + CW'(1);
            end
            if (emit) begin
                out_word_q <= word_d;
                out_addr_q <= base_q + widx_q;
            end
            if (start_job) begin
                base_q <= bus.base_addr;
                acc_q  <= '0;
                widx_q <= '0;
                buf_q  <= '0;
                cnt_q  <= '0;
`ifdef CPACK_CHECKSUM_EN
                chk_q  <= '0;
`endif
            end else begin
                buf_q <= buf_d;
                cnt_q <= cnt_d;
                if (emit) begin
                    widx_q <= widx_q + 11'd1;
`ifdef CPACK_CHECKSUM_EN
                    chk_q  <= chk_q ^ word_d;
`endif
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == S_RUN);
    assign bus.busy      = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign bus.done      = (state_q == S_DONE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.dbg_state = state_q;
`ifdef CPACK_CHECKSUM_EN
    assign bus.chk       = chk_q;
`endif
endmodule

// File: tb/tb_coeff_compress_pack.sv
// Randomized bench for coeff_compress_pack: bit-level reference packing model,
// expected word/address queues, and a single summary line.
module tb_coeff_compress_pack;
    localparam int QV = 7681;
    localparam int DV = 10;
    localparam int NA = 64;
    localparam int NB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    coeff_compress_pack_if a_if();
    coeff_compress_pack_if b_if();

    coeff_compress_pack #(.Q(QV), .D(DV), .NCOEF(NA)) u_dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    coeff_compress_pack #(.Q(QV), .D(DV), .NCOEF(NB)) u_dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    int n_cmp = 0;
    int n_err = 0;
    int coefs[NA];
    logic [15:0] exp_q[$];
    logic [10:0] exp_a_q[$];
    logic [15:0] obs_w[$];
    logic [15:0] obs_b[$];
    bit mon_en = 1'b0;
    int last_strobe_cyc = 0;
    logic [15:0] prev_w = '0;
    logic [10:0] prev_a = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: rounded compression from its defining formula.
    function automatic int cmp(input int x);
        longint num;
        num = (longint'(x) << (DV + 1)) + QV;
        return int'((num / (2 * QV)) % (64'd1 << DV));
    endfunction

    // Word w of the packed stream: bit p of the stream is bit (p mod D) of coefficient p/D.
    function automatic logic [15:0] model_word(input int w, input int n);
        logic [15:0] r;
        r = '0;
        for (int b = 0; b < 16; b++) begin
            int pos;
            int k;
            pos = 16 * w + b;
            k   = pos / DV;
            if (k < n) r[b] = ((cmp(coefs[k]) >> (pos % DV)) & 1) != 0;
        end
        return r;
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < NA; i++) begin
            case (mode)
                0: coefs[i] = 3840;
                1: coefs[i] = $urandom_range(0, QV - 1);
                2: coefs[i] = 0;
                3: coefs[i] = (i == 0) ? 3840 : 0;
                default: coefs[i] = 0;
            endcase
        end
        if (mode == 4) begin
            coefs[0] = 3840; coefs[1] = 7680; coefs[2] = 1; coefs[3] = 4; coefs[4] = 3840;
        end
    endtask

    // Scoreboard for DUT A: every strobe must match the head of the expected queues.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (a_if.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 32'd1, 32'd0);
                end else begin
                    check("word", {16'd0, a_if.out_word}, {16'd0, exp_q.pop_front()});
                    check("addr", {21'd0, a_if.out_addr}, {21'd0, exp_a_q.pop_front()});
                end
                obs_w.push_back(a_if.out_word);
                last_strobe_cyc = cyc;
            end else begin
                check("hold", {5'd0, a_if.out_addr, a_if.out_word}, {5'd0, prev_a, prev_w});
            end
        end
        prev_w = a_if.out_word;
        prev_a = a_if.out_addr;
    end

    always @(negedge clk) if (!rst && b_if.out_valid) obs_b.push_back(b_if.out_word);

    task automatic check_zero_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, a_if.in_ready}, 32'd0);
        check({tag, "_out_valid"}, {31'd0, a_if.out_valid}, 32'd0);
        check({tag, "_out_word"}, {16'd0, a_if.out_word}, 32'd0);
        check({tag, "_out_addr"}, {21'd0, a_if.out_addr}, 32'd0);
        check({tag, "_busy"}, {31'd0, a_if.busy}, 32'd0);
        check({tag, "_done"}, {31'd0, a_if.done}, 32'd0);
        check({tag, "_state"}, {30'd0, a_if.dbg_state}, 32'd0);
`ifdef CPACK_CHECKSUM_EN
        check({tag, "_chk"}, {16'd0, a_if.chk}, 32'd0);
`endif
    endtask

    task automatic pulse_start_a(input int base);
        a_if.start = 1'b1;
        a_if.base_addr = 11'(base);
        @(posedge clk); #1;
        a_if.start = 1'b0;
        a_if.base_addr = 11'($urandom_range(0, 2047));
    endtask

    task automatic run_job(input int base, input bit gaps, input bit poke);
        int nwords;
        int i;
        int budget;
        int k;
        bit acc;
        bit got;
        logic [15:0] x;
        nwords = (NA * DV + 15) / 16;
        obs_w.delete();
        x = '0;
        for (int w = 0; w < nwords; w++) begin
            exp_q.push_back(model_word(w, NA));
            exp_a_q.push_back(11'(base + w));
            x ^= model_word(w, NA);
        end
        pulse_start_a(base);
        check("ready_rise", {31'd0, a_if.in_ready}, 32'd1);
        check("busy_rise", {31'd0, a_if.busy}, 32'd1);
        i = 0;
        budget = 0;
        while (i < NA && budget < 2000) begin
            a_if.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            a_if.in_coeff = 13'(coefs[i]);
            if (poke && i == 10) begin
                a_if.start = 1'b1;
                a_if.base_addr = 11'($urandom_range(0, 2047));
            end
            #2;
            acc = a_if.in_valid && a_if.in_ready;
            @(posedge clk); #1;
            a_if.start = 1'b0;
            if (acc) i++;
            budget++;
        end
        if (i < NA) check("feed_timeout", i, NA);
        // Keep offering data past the last accept: none of it may be taken.
        a_if.in_valid = 1'b1;
        a_if.in_coeff = 13'd3840;
        check("ready_drop", {31'd0, a_if.in_ready}, 32'd0);
        k = 0;
        got = 1'b0;
        while (!got && k < 300) begin
            if (a_if.done) begin
                got = 1'b1;
            end else begin
                @(posedge clk); #1;
                k++;
                if (k == 3) a_if.in_valid = 1'b0;
            end
        end
        a_if.in_valid = 1'b0;
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("done_latency", cyc, last_strobe_cyc + 1);
            check("busy_at_done", {31'd0, a_if.busy}, 32'd0);
            check("n_words", obs_w.size(), nwords);
            check("words_left", exp_q.size(), 32'd0);
`ifdef CPACK_CHECKSUM_EN
            check("chk", {16'd0, a_if.chk}, {16'd0, x});
`endif
            @(posedge clk); #1;
            check("done_pulse", {31'd0, a_if.done}, 32'd0);
`ifdef CPACK_CHECKSUM_EN
            check("chk_held", {16'd0, a_if.chk}, {16'd0, x});
`endif
        end
        exp_q.delete();
        exp_a_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        a_if.start = 0; a_if.base_addr = 0; a_if.in_valid = 0; a_if.in_coeff = 0;
        b_if.start = 0; b_if.base_addr = 0; b_if.in_valid = 0; b_if.in_coeff = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_zero_outputs("reset");
        mon_en = 1'b1;

        // All mid-scale values: 40 words, every one 0x0200-based pattern.
        fill(0);
        run_job(5, 1'b0, 1'b0);
        check("pack_w0", {16'd0, obs_w[0]}, 32'h0200);

        // Rounding corner values packed into the first words.
        fill(4);
        run_job(100, 1'b0, 1'b0);
        check("round_w0", {16'd0, obs_w[0]}, 32'h0200);
        check("round_w1", {16'd0, obs_w[1]}, 32'h4000);
        check("round_w2", {16'd0, obs_w[2]}, 32'h0000);
        check("round_w3", {16'd0, obs_w[3]}, 32'h0002);

        // Address wrap, once gap-free and once throttled with an ignored start.
        fill(1);
        run_job(2046, 1'b0, 1'b0);
        run_job(2046, 1'b1, 1'b1);

        fill(2);
        run_job(700, 1'b1, 1'b0);
        fill(3);
        run_job(9, 1'b0, 1'b1);

        // Reset after five accepted coefficients.
        mon_en = 1'b0;
        fill(0);
        pulse_start_a(300);
        a_if.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_if.in_coeff = 13'(coefs[i]);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a_if.in_valid = 1'b0;
        check_zero_outputs("midrst");
        @(posedge clk); #1;
        exp_q.delete();
        exp_a_q.delete();
        mon_en = 1'b1;
        fill(1);
        run_job(400, 1'b0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            fill(1);
            run_job($urandom_range(0, 2047), 1'b1, r[0]);
        end

        // Short job: three coefficients give one full word and one padded word.
        fill(1);
        obs_b.delete();
        b_if.start = 1'b1;
        b_if.base_addr = 11'd7;
        @(posedge clk); #1;
        b_if.start = 1'b0;
        b_if.in_valid = 1'b1;
        for (int i = 0; i < NB; i++) begin
            b_if.in_coeff = 13'(coefs[i]);
            @(posedge clk); #1;
        end
        b_if.in_valid = 1'b0;
        k = 0;
        while (!b_if.done && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("b_done_seen", {31'd0, b_if.done}, 32'd1);
        check("b_n_words", obs_b.size(), 32'd2);
        if (obs_b.size() >= 2) begin
            check("b_w0", {16'd0, obs_b[0]}, {16'd0, model_word(0, NB)});
            check("b_w1", {16'd0, obs_b[1]}, {16'd0, model_word(1, NB)});
            check("b_pad", {30'd0, obs_b[1][15:14]}, 32'd0);
            check("b_c2", {22'd0, obs_b[1][13:4]}, cmp(coefs[2]));
        end
        check("b_addr_last", {21'd0, b_if.out_addr}, 32'd8);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
